priority_encoder_drain: RTL and testbench

//  Parametrised, registered successor to the fixed 8-to-3 priority encoder.
//  - Captures a WIDTH-bit request vector through a valid/ready handshake.
//  - Drains the set bits one index per cycle, highest index first, through an output valid/ready handshake.
//  - Sits between request collectors (interrupt/event lines) and a consumer that services one index at a time.

---
 rtl/priority_encoder_drain_pkg.sv | 29 ++
 rtl/priority_encoder_drain_find_msb.sv | 31 +++
 rtl/priority_encoder_drain.sv | 149 ++++++++++++++
 tb/tb_priority_encoder_drain.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/priority_encoder_drain_pkg.sv
// -----------------------------------------------------------------------------
// penc_pkg
// Shared types and helpers for the priority_encoder_drain block.
//   penc_state_t     : two-state control (IDLE waits for a vector, SCAN drains it)
//   PENC_MAX_W       : widest request vector the helper function supports
//   popcount_is_one  : true when exactly one bit of a (zero-extended) vector is set
// -----------------------------------------------------------------------------
package penc_pkg;

    typedef enum logic {
        PENC_IDLE = 1'b0,
        PENC_SCAN = 1'b1
    } penc_state_t;

    // Request vectors are zero-extended to this width before the one-hot test,
    // so the block supports WIDTH up to 64.
    localparam int PENC_MAX_W = 64;

    // A vector has exactly one bit set when it is nonzero and clearing its
    // lowest set bit leaves nothing behind.
    function automatic logic popcount_is_one(input logic [PENC_MAX_W-1:0] vec);
        logic [PENC_MAX_W-1:0] one_v;
        logic [PENC_MAX_W-1:0] zero_v;
        one_v  = {{(PENC_MAX_W-1){1'b0}}, 1'b1};
        zero_v = {PENC_MAX_W{1'b0}};
        popcount_is_one = (vec != zero_v) && ((vec & (vec - one_v)) == zero_v);
    endfunction

endpackage

// File: rtl/priority_encoder_drain_find_msb.sv
// -----------------------------------------------------------------------------
// priority_find_msb
// Purely combinational most-significant-set-bit finder.
// Parameters:
//   WIDTH  input vector width (>= 2)
//   IDX_W  index width, $clog2(WIDTH)
// Ports:
//   vec    in   WIDTH  vector to search
//   idx    out  IDX_W  index of the highest set bit (0 when vec is zero)
//   found  out  1      vec has at least one bit set
// -----------------------------------------------------------------------------
module priority_find_msb #(
    parameter  int WIDTH = 8,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Ascending scan: a later (higher) set bit overrides earlier ones, so the
    // final value is the MSB index. Only indices below WIDTH can be produced.
    always_comb begin
        idx   = {IDX_W{1'b0}};
        found = |vec;
        for (int i = 0; i < WIDTH; i++) begin
            idx = vec[i] ? IDX_W'(i) : idx;
        end
    end

endmodule

// File: rtl/priority_encoder_drain.sv
// -----------------------------------------------------------------------------
// priority_encoder_drain
// Captures a WIDTH-bit request vector through a valid/ready handshake and
// drains its set bits one index per cycle, highest index first, through an
// output valid/ready handshake. A new vector may be accepted on the last beat
// of the current one with no idle cycle in between.
// Optional feature macro: PENC_ONEHOT_EN (adds the out_onehot port).
// Parameters:
//   WIDTH      request vector width (2..64, non-power-of-2 allowed)
//   IDX_W      $clog2(WIDTH), width of out_idx
// Ports:
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      in_req is valid
//   in_ready   out  1      block accepts in_req this cycle
//   in_req     in   WIDTH  request vector, bit i requests index i
//   out_valid  out  1      out_idx is valid
//   out_ready  in   1      consumer takes out_idx this cycle
//   out_idx    out  IDX_W  highest set index of the pending vector
//   out_last   out  1      this beat is the last set bit of the vector
//   out_onehot out  WIDTH  (PENC_ONEHOT_EN only) one-hot form of out_idx
//   busy       out  1      a vector is being drained
// -----------------------------------------------------------------------------
module priority_encoder_drain
    import penc_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
`ifdef PENC_ONEHOT_EN
    output logic [WIDTH-1:0] out_onehot,
`endif
    output logic             busy
);

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

    penc_state_t      state_r;
    penc_state_t      next_state_s;
    logic [WIDTH-1:0] pending_r;
    logic [WIDTH-1:0] next_pending_s;

    logic [IDX_W-1:0] msb_idx_s;
    logic             msb_found_s;
    logic             scan_s;
    logic             valid_s;
    logic             last_s;
    logic             in_ready_s;
    logic             accept_s;
    logic             beat_s;
    logic             req_nonzero_s;

    priority_find_msb #(
        .WIDTH (WIDTH)
    ) u_find_msb (
        .vec   (pending_r),
        .idx   (msb_idx_s),
        .found (msb_found_s)
    );

    // Everything visible at the output is decoded from the state and pending
    // registers; the found flag keeps a beat from ever being offered on an
    // empty pending vector.
    assign scan_s        = (state_r == PENC_SCAN);
    assign valid_s       = scan_s && msb_found_s;
    assign last_s        = valid_s && popcount_is_one(PENC_MAX_W'(pending_r));
    assign in_ready_s    = (state_r == PENC_IDLE) || (scan_s && out_ready && last_s);
    assign accept_s      = in_valid && in_ready_s;
    assign beat_s        = valid_s && out_ready;
    assign req_nonzero_s = (in_req != ZERO_W);

    assign in_ready  = in_ready_s;
    assign out_valid = valid_s;
    assign out_idx   = valid_s ? msb_idx_s : {IDX_W{1'b0}};
    assign out_last  = last_s;
    assign busy      = scan_s;

`ifdef PENC_ONEHOT_EN
    assign out_onehot = valid_s ? (ONE_W << msb_idx_s) : ZERO_W;
`endif

    // Next-state and next-pending decode. A zero vector is accepted but
    // dropped; a vector accepted on the last beat reloads pending directly.
    always_comb begin
        next_state_s   = state_r;
        next_pending_s = pending_r;
        case (state_r)
            PENC_IDLE: begin
                if (accept_s && req_nonzero_s) begin
                    next_state_s   = PENC_SCAN;
                    next_pending_s = in_req;
                end else begin
                    next_state_s   = PENC_IDLE;
                    next_pending_s = ZERO_W;
                end
            end
            PENC_SCAN: begin
                if (beat_s) begin
                    if (last_s) begin
                        if (accept_s && req_nonzero_s) begin
                            next_state_s   = PENC_SCAN;
                            next_pending_s = in_req;
                        end else begin
                            next_state_s   = PENC_IDLE;
                            next_pending_s = ZERO_W;
                        end
                    end else begin
                        next_state_s   = PENC_SCAN;
                        next_pending_s = pending_r & ~(ONE_W << msb_idx_s);
                    end
                end else if (!msb_found_s) begin
                    // Unreachable in normal operation: recover from an empty
                    // pending vector rather than stalling in SCAN.
                    next_state_s   = PENC_IDLE;
                    next_pending_s = ZERO_W;
                end else begin
                    next_state_s   = PENC_SCAN;
                    next_pending_s = pending_r;
                end
            end
            default: begin
                next_state_s   = PENC_IDLE;
                next_pending_s = ZERO_W;
            end
        endcase
    end

    // State and pending-vector registers; reset drops any undrained bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= PENC_IDLE;
            pending_r <= ZERO_W;
        end else begin
            state_r   <= next_state_s;
            pending_r <= next_pending_s;
        end
    end

endmodule

// File: tb/tb_priority_encoder_drain.sv
module tb_priority_encoder_drain;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_req;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_idx;
    logic        out_last;
    logic        busy;

    logic        in_valid12;
    logic        in_ready12;
    logic [11:0] in_req12;
    logic        out_valid12;
    logic        out_ready12;
    logic [3:0]  out_idx12;
    logic        out_last12;
    logic        busy12;
`ifdef PENC_ONEHOT_EN
    logic [7:0]  out_onehot;
    logic [11:0] out_onehot12;
`endif

    typedef struct {
        int idx;
        bit last;
    } beat_t;

    beat_t sb_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    priority_encoder_drain #(.WIDTH(8)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_req     (in_req),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_last   (out_last),
`ifdef PENC_ONEHOT_EN
        .out_onehot (out_onehot),
`endif
        .busy       (busy)
    );

    priority_encoder_drain #(.WIDTH(12)) u_dut12 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid12),
        .in_ready   (in_ready12),
        .in_req     (in_req12),
        .out_valid  (out_valid12),
        .out_ready  (out_ready12),
        .out_idx    (out_idx12),
        .out_last   (out_last12),
`ifdef PENC_ONEHOT_EN
        .out_onehot (out_onehot12),
`endif
        .busy       (busy12)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected beats of an 8-bit vector: set bits from MSB down; the last
    // beat is the one with no lower set bit remaining.
    task automatic push_vec8(input logic [7:0] vec);
        beat_t      b;
        logic [7:0] lowmask;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) begin
                lowmask = (8'd1 << i) - 8'd1;
                b.idx   = i;
                b.last  = ((vec & lowmask) == 8'd0);
                sb_q.push_back(b);
            end
        end
    endtask

    task automatic expect_beat(input string tag);
        beat_t b;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            b = sb_q[0];
            check({tag, "_valid"}, out_valid, 1'b1);
            check({tag, "_idx"}, out_idx, b.idx);
            check({tag, "_last"}, out_last, b.last);
            check({tag, "_busy"}, busy, 1'b1);
`ifdef PENC_ONEHOT_EN
            check({tag, "_onehot"}, out_onehot, 32'd1 << b.idx);
`endif
            if (out_ready) void'(sb_q.pop_front());
        end
    endtask

    task automatic drive_accept8(input logic [7:0] vec);
        in_valid = 1'b1;
        in_req   = vec;
        @(negedge clk);
        check("accept_ready", in_ready, 1'b1);
        push_vec8(vec);
        step();
        in_valid = 1'b0;
        in_req   = 8'h00;
    endtask

    task automatic drain(input string tag, input int max_cycles);
        int n = 0;
        while (sb_q.size() > 0 && n < max_cycles) begin
            @(negedge clk);
            expect_beat(tag);
            step();
            n++;
        end
        check({tag, "_drained"}, sb_q.size(), 32'd0);
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        check({tag, "_in_ready"}, in_ready, 1'b1);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_req      = 8'h00;
        out_ready   = 1'b1;
        in_valid12  = 1'b0;
        in_req12    = 12'h000;
        out_ready12 = 1'b1;

        // Reset state
        #3;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_idx", out_idx, 3'd0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst12_out_valid", out_valid12, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // 1: 1010_0100 drains 7,5,2 back to back
        drive_accept8(8'b1010_0100);
        drain("t1", 10);
        check_idle("t1_end");
        step();

        // 2: backpressure holds idx 7 and ignores in_req
        out_ready = 1'b0;
        drive_accept8(8'b1010_0100);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_req   = 8'hFF;
            @(negedge clk);
            check("t2_hold_valid", out_valid, 1'b1);
            check("t2_hold_idx", out_idx, 3'd7);
            check("t2_hold_last", out_last, 1'b0);
            check("t2_hold_in_ready", in_ready, 1'b0);
            step();
        end
        in_valid  = 1'b0;
        in_req    = 8'h00;
        out_ready = 1'b1;
        drain("t2", 10);
        check_idle("t2_end");
        step();

        // 3: 8'h01 accepted on the last beat, no bubble
        drive_accept8(8'b1010_0100);
        @(negedge clk);
        expect_beat("t3_b7");
        step();
        @(negedge clk);
        expect_beat("t3_b5");
        step();
        in_valid = 1'b1;
        in_req   = 8'h01;
        @(negedge clk);
        check("t3_b2b_ready", in_ready, 1'b1);
        expect_beat("t3_b2");
        push_vec8(8'h01);
        step();
        in_valid = 1'b0;
        in_req   = 8'h00;
        @(negedge clk);
        expect_beat("t3_b0");
        step();
        check_idle("t3_end");
        step();

        // 4: zero vector accepted and discarded
        in_valid = 1'b1;
        in_req   = 8'h00;
        @(negedge clk);
        check("t4_in_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        check_idle("t4_after");
        step();
        check_idle("t4_after2");
        step();

        // 5: async reset after the idx 7 handshake
        drive_accept8(8'hFF);
        @(negedge clk);
        expect_beat("t5_b7");
        step();
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", out_valid, 1'b0);
        check("t5_rst_in_ready", in_ready, 1'b1);
        check("t5_rst_busy", busy, 1'b0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t5_no_beat", out_valid, 1'b0);
        end
        step();

        // 6: WIDTH=12, 12'h801 drains 11 then 0
        in_valid12 = 1'b1;
        in_req12   = 12'h801;
        @(negedge clk);
        check("t6_in_ready", in_ready12, 1'b1);
        step();
        in_valid12 = 1'b0;
        in_req12   = 12'h000;
        @(negedge clk);
        check("t6_b11_valid", out_valid12, 1'b1);
        check("t6_b11_idx", out_idx12, 4'd11);
        check("t6_b11_last", out_last12, 1'b0);
`ifdef PENC_ONEHOT_EN
        check("t6_b11_onehot", out_onehot12, 12'h800);
`endif
        step();
        @(negedge clk);
        check("t6_b0_valid", out_valid12, 1'b1);
        check("t6_b0_idx", out_idx12, 4'd0);
        check("t6_b0_last", out_last12, 1'b1);
`ifdef PENC_ONEHOT_EN
        check("t6_b0_onehot", out_onehot12, 12'h001);
`endif
        step();
        @(negedge clk);
        check("t6_end_valid", out_valid12, 1'b0);
        check("t6_end_busy", busy12, 1'b0);
`ifdef PENC_ONEHOT_EN
        check("t6_end_onehot", out_onehot12, 12'h000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
